// File: rtl/gpt_trig_pkg.sv
// Shared types and constants for the timer trigger path (master and slave side).
package gpt_trig_pkg;

   // Master mode select encodings driving the TRGO source mux.
   typedef enum logic [2:0] {
      MMS_RESET     = 3'b000,
      MMS_ENABLE    = 3'b001,
      MMS_UPDATE    = 3'b010,
      MMS_CMP_PULSE = 3'b011,
      MMS_OC1REF    = 3'b100,
      MMS_OC2REF    = 3'b101,
      MMS_OC3REF    = 3'b110,
      MMS_OC4REF    = 3'b111
   } mms_e;

   // Pulse stretcher FSM states.
   typedef enum logic {
      MM_IDLE  = 1'b0,
      MM_PULSE = 1'b1
   } mm_state_e;

   localparam int unsigned PULSE_W_MAX_DEFAULT = 15;

endpackage : gpt_trig_pkg

// File: rtl/trgo_pulse_stretcher.sv
// Stretches single-cycle trigger events to a programmable width, with retrigger.
// Ports:
//   clk_i, aresetn_i : kernel clock, async active-low reset
//   evt_i            : event strobe (already gated by the caller)
//   clr_i            : synchronous clear to IDLE, wins over evt_i
//   pw_i             : pulse width in cycles, 0 treated as 1; sampled at load/reload
//   pulse_o          : stretched pulse
//   busy_o           : FSM is in PULSE
module trgo_pulse_stretcher
   import gpt_trig_pkg::*;
#(
   parameter  int unsigned PULSE_W_MAX = PULSE_W_MAX_DEFAULT,
   localparam int unsigned PW_W        = $clog2(PULSE_W_MAX + 1)
) (
   input  logic            clk_i,
   input  logic            aresetn_i,
   input  logic            evt_i,
   input  logic            clr_i,
   input  logic [PW_W-1:0] pw_i,
   output logic            pulse_o,
   output logic            busy_o
);

   mm_state_e       state_q;
   logic [PW_W-1:0] cnt_q;
   logic [PW_W-1:0] load_c;
   logic            pulse_q;

   // Counter holds remaining cycles after the current one, so width N loads N-1.
   assign load_c = (pw_i == '0) ? '0 : pw_i - PW_W'(1);

   // FSM, down-counter and registered pulse.
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state_q <= MM_IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else if (clr_i) begin
         state_q <= MM_IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         case (state_q)
            MM_IDLE: begin
               if (evt_i) begin
                  state_q <= MM_PULSE;
                  cnt_q   <= load_c;
                  pulse_q <= 1'b1;
               end
            end
            MM_PULSE: begin
               if (evt_i) begin
                  cnt_q <= load_c;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - PW_W'(1);
               end else begin
                  state_q <= MM_IDLE;
                  pulse_q <= 1'b0;
               end
            end
            default: begin
               state_q <= MM_IDLE;
               cnt_q   <= '0;
               pulse_q <= 1'b0;
            end
         endcase
      end
   end

   assign pulse_o = pulse_q;
   assign busy_o  = (state_q == MM_PULSE);

endmodule : trgo_pulse_stretcher

// File: rtl/master_mode_controller.sv
// Timer master mode controller: selects and conditions the TRGO source and
// provides the MSM delay on the local slave trigger.
// Ports:
//   clk_i, aresetn_i : kernel clock, async active-low reset
//   mms_i            : master mode select
//   msm_i            : delay trgi_i by one register to match TRGO latency
//   pw_i             : event pulse width (0 treated as 1)
//   ug_i, slv_rst_i, uev_i, cc1_evt_i : event strobes
//   cen_i, oc_ref_i  : level sources
//   trgi_i           : local slave trigger
//   trgo_o           : trigger output to other timers
//   trgi_sync_o      : local trigger to slave logic
//   busy_o           : event pulse in progress
module master_mode_controller
   import gpt_trig_pkg::*;
#(
   parameter  int unsigned CH_PAIRS_NUM = 2,
   parameter  int unsigned PULSE_W_MAX  = PULSE_W_MAX_DEFAULT,
   localparam int unsigned PW_W         = $clog2(PULSE_W_MAX + 1),
   localparam int unsigned OC_W         = 2 * CH_PAIRS_NUM
) (
   input  logic            clk_i,
   input  logic            aresetn_i,
   input  logic [2:0]      mms_i,
   input  logic            msm_i,
   input  logic [PW_W-1:0] pw_i,
   input  logic            ug_i,
   input  logic            slv_rst_i,
   input  logic            cen_i,
   input  logic            uev_i,
   input  logic            cc1_evt_i,
   input  logic [OC_W-1:0] oc_ref_i,
   input  logic            trgi_i,
   output logic            trgo_o,
   output logic            trgi_sync_o,
   output logic            busy_o
);

   mms_e       mms_q;
   logic       mode_chg_c;
   logic       level_mode_c;
   logic       level_c;
   logic       evt_c;
   logic       level_q;
   logic       pulse;
   logic       trgi_q;
   logic [3:0] oc_pad;

   // OC references padded to the four selectable indices; missing channels read 0.
   for (genvar g = 0; g < 4; g++) begin : g_oc_pad
      if (g < OC_W) begin : g_present
         assign oc_pad[g] = oc_ref_i[g];
      end else begin : g_absent
         assign oc_pad[g] = 1'b0;
      end
   end

   // Mode change is seen on the cycle mms_i differs from the registered mode,
   // so TRGO drops the next cycle and the new source drives the one after.
   assign mode_chg_c = (mms_i != 3'(mms_q));

   // Source mux on the registered mode.
   always_comb begin
      level_mode_c = 1'b0;
      level_c      = 1'b0;
      evt_c        = 1'b0;
      case (mms_q)
         MMS_RESET:     evt_c = ug_i | slv_rst_i;
         MMS_ENABLE: begin
            level_mode_c = 1'b1;
            level_c      = cen_i;
         end
         MMS_UPDATE:    evt_c = uev_i;
         MMS_CMP_PULSE: evt_c = cc1_evt_i;
         default: begin
            level_mode_c = 1'b1;
            level_c      = oc_pad[mms_q[1:0]];
         end
      endcase
   end

   // Mode, level and MSM delay registers.
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         mms_q   <= MMS_RESET;
         level_q <= 1'b0;
         trgi_q  <= 1'b0;
      end else begin
         mms_q   <= mms_e'(mms_i);
         level_q <= level_mode_c & level_c & ~mode_chg_c;
         trgi_q  <= trgi_i;
      end
   end

   trgo_pulse_stretcher #(
      .PULSE_W_MAX (PULSE_W_MAX)
   ) u_stretcher (
      .clk_i     (clk_i),
      .aresetn_i (aresetn_i),
      .evt_i     (evt_c & ~mode_chg_c),
      .clr_i     (mode_chg_c),
      .pw_i      (pw_i),
      .pulse_o   (pulse),
      .busy_o    (busy_o)
   );

   // level_q is only set in level modes and pulse only in event modes.
   assign trgo_o      = level_q | pulse;
   assign trgi_sync_o = msm_i ? trgi_q : trgi_i;

endmodule : master_mode_controller

// File: tb/tb_master_mode_controller.sv
// Directed self-checking bench for master_mode_controller (CH_PAIRS_NUM=1).
module tb_master_mode_controller;

   logic       clk;
   logic       aresetn;
   logic [2:0] mms;
   logic       msm;
   logic [3:0] pw;
   logic       ug, slv_rst, cen, uev, cc1_evt;
   logic [1:0] oc_ref;
   logic       trgi;
   logic       trgo, trgi_sync, busy;

   int n_checks = 0;
   int n_fail   = 0;

   master_mode_controller #(
      .CH_PAIRS_NUM (1),
      .PULSE_W_MAX  (15)
   ) dut (
      .clk_i       (clk),
      .aresetn_i   (aresetn),
      .mms_i       (mms),
      .msm_i       (msm),
      .pw_i        (pw),
      .ug_i        (ug),
      .slv_rst_i   (slv_rst),
      .cen_i       (cen),
      .uev_i       (uev),
      .cc1_evt_i   (cc1_evt),
      .oc_ref_i    (oc_ref),
      .trgi_i      (trgi),
      .trgo_o      (trgo),
      .trgi_sync_o (trgi_sync),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic set_mode(input logic [2:0] m);
      mms = m;
      cyc();
      cyc();
   endtask

   initial begin
      aresetn = 1'b0;
      mms = 3'b010; msm = 1'b0; pw = 4'd3;
      ug = 0; slv_rst = 0; cen = 0; uev = 0; cc1_evt = 0;
      oc_ref = 2'b00; trgi = 0;

      // Reset state
      #13;
      chk("rst_trgo", trgo, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_trgi_sync", trgi_sync, 1'b0);
      aresetn = 1'b1;
      cyc(); cyc(); cyc();

      // UPDATE mode, pw=3, single event
      uev = 1; cyc(); uev = 0;
      chk("upd_c11", trgo, 1'b1); chk("upd_busy_c11", busy, 1'b1);
      cyc(); chk("upd_c12", trgo, 1'b1);
      cyc(); chk("upd_c13", trgo, 1'b1); chk("upd_busy_c13", busy, 1'b1);
      cyc(); chk("upd_c14", trgo, 1'b0); chk("upd_busy_c14", busy, 1'b0);

      // RESET mode, pw=4, retrigger extends pulse; pw change mid-pulse ignored
      pw = 4'd4;
      set_mode(3'b000);
      ug = 1; cyc(); ug = 0;
      chk("rst_c6", trgo, 1'b1);
      cyc(); slv_rst = 1; chk("rst_c7", trgo, 1'b1);
      cyc(); slv_rst = 0; chk("rst_c8", trgo, 1'b1);
      cyc(); pw = 4'd15; chk("rst_c9", trgo, 1'b1);
      cyc(); chk("rst_c10", trgo, 1'b1);
      cyc(); chk("rst_c11", trgo, 1'b1);
      cyc(); chk("rst_c12", trgo, 1'b0); chk("rst_busy_c12", busy, 1'b0);

      // Simultaneous ug and slv_rst, pw=2
      pw = 4'd2;
      ug = 1; slv_rst = 1; cyc(); ug = 0; slv_rst = 0;
      chk("sim_1", trgo, 1'b1);
      cyc(); chk("sim_2", trgo, 1'b1);
      cyc(); chk("sim_3", trgo, 1'b0);

      // CMP_PULSE mode, pw=0, two consecutive events
      pw = 4'd0;
      set_mode(3'b011);
      cc1_evt = 1; cyc();
      chk("cmp_c21", trgo, 1'b1);
      cyc(); cc1_evt = 0; chk("cmp_c22", trgo, 1'b1);
      cyc(); chk("cmp_c23", trgo, 1'b0);

      // Maximum width pulse
      pw = 4'd15;
      cc1_evt = 1; cyc(); cc1_evt = 0;
      for (int i = 0; i < 15; i++) begin
         chk("cmp_max_hi", trgo, 1'b1);
         cyc();
      end
      chk("cmp_max_lo", trgo, 1'b0);
      chk("cmp_max_busy", busy, 1'b0);

      // OCREF sweep with one channel pair
      oc_ref = 2'b00;
      set_mode(3'b101);
      chk("oc2_lo", trgo, 1'b0);
      oc_ref = 2'b10; cyc(); chk("oc2_hi", trgo, 1'b1); chk("oc2_busy", busy, 1'b0);
      oc_ref = 2'b00; cyc(); chk("oc2_lo2", trgo, 1'b0);
      oc_ref = 2'b11; cyc(); chk("oc2_hi2", trgo, 1'b1);
      mms = 3'b100; cyc(); chk("oc1_chg_gap", trgo, 1'b0);
      cyc(); chk("oc1_hi", trgo, 1'b1);
      set_mode(3'b110);
      chk("oc3_absent", trgo, 1'b0);
      cyc(); chk("oc3_absent2", trgo, 1'b0);
      set_mode(3'b111);
      chk("oc4_absent", trgo, 1'b0);
      oc_ref = 2'b00;

      // Mode change mid-pulse: UPDATE pw=8 -> ENABLE with cen=1
      pw = 4'd8;
      set_mode(3'b010);
      uev = 1; cyc(); uev = 0;
      chk("mc_c4", trgo, 1'b1);
      cyc(); chk("mc_c5", trgo, 1'b1);
      cyc(); mms = 3'b001; cen = 1; chk("mc_c6", trgo, 1'b1);
      cyc(); chk("mc_c7", trgo, 1'b0); chk("mc_busy_c7", busy, 1'b0);
      cyc(); chk("mc_c8", trgo, 1'b1); chk("mc_busy_c8", busy, 1'b0);

      // Event coincident with mode change is dropped
      mms = 3'b010; uev = 1; cyc(); uev = 0; cen = 0;
      chk("drop_1", trgo, 1'b0); chk("drop_busy_1", busy, 1'b0);
      cyc(); chk("drop_2", trgo, 1'b0); chk("drop_busy_2", busy, 1'b0);

      // MSM delay path
      msm = 1; trgi = 1; #1;
      chk("msm1_c4", trgi_sync, 1'b0);
      cyc(); trgi = 0; #1;
      chk("msm1_c5", trgi_sync, 1'b1);
      cyc(); chk("msm1_c6", trgi_sync, 1'b0);
      msm = 0; trgi = 1; #1;
      chk("msm0_c4", trgi_sync, 1'b1);
      cyc(); trgi = 0; #1;
      chk("msm0_c5", trgi_sync, 1'b0);

      // Async reset mid-pulse, then first event after release
      uev = 1; cyc(); uev = 0;
      chk("ar_pre_busy", busy, 1'b1);
      #2 aresetn = 1'b0;
      #1;
      chk("ar_trgo", trgo, 1'b0);
      chk("ar_busy", busy, 1'b0);
      mms = 3'b000;
      cyc();
      #2 aresetn = 1'b1;
      ug = 1; cyc(); ug = 0;
      chk("ar_first_evt", trgo, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_master_mode_controller

// File: doc/master_mode_controller.md
Name: master_mode_controller

Overview:
- Master-side counterpart of the slave-mode trigger path: generates the timer's trigger output TRGO.
- TRGO drives the itr inputs of other timer instances.
- The TRGO source is selected by MMS. Event sources are stretched to a programmable pulse width so a slower or filtered slave can capture them.
- Also provides the MSM (master/slave mode) delay: the local slave trigger is delayed by the same latency as TRGO, so master and slaves start in lockstep.

Parameters:
- CH_PAIRS_NUM, 2, number of capture/compare channel pairs; oc_ref_i width is 2*CH_PAIRS_NUM.
- PULSE_W_MAX, 15, maximum programmable TRGO pulse width in clk_i cycles. Width of pw_i is $clog2(PULSE_W_MAX+1).

Ports:
- clk_i  input  1  timer kernel clock.
- aresetn_i  input  1  asynchronous, active-low reset.
- mms_i  input  3  master mode select.
- msm_i  input  1  master/slave mode: delay the local trigger.
- pw_i  input  $clog2(PULSE_W_MAX+1)  TRGO pulse width for event modes; 0 is treated as 1.
- ug_i  input  1  software update-generation strobe (1 cycle).
- slv_rst_i  input  1  counter reset caused by slave reset mode (1 cycle).
- cen_i  input  1  counter enable level (CEN, or the slave-gated enable).
- uev_i  input  1  update event strobe (1 cycle).
- cc1_evt_i  input  1  CC1IF set strobe from capture or compare match (1 cycle).
- oc_ref_i  input  2*CH_PAIRS_NUM  OCxREF levels.
- trgi_i  input  1  local slave trigger from the trigger selector.
- trgo_o  output  1  trigger output to other timers.
- trgi_sync_o  output  1  local trigger to the slave logic, with optional delay.
- busy_o  output  1  an event pulse is in progress.

Behaviour:
- Reset values: trgo_o=0, trgi_sync_o=0, busy_o=0, FSM=IDLE, counter=0, mode register=000.
- Source map, selected by mms_i:
  - 000 RESET: event = ug_i | slv_rst_i.
  - 001 ENABLE: level = cen_i.
  - 010 UPDATE: event = uev_i.
  - 011 CMP_PULSE: event = cc1_evt_i.
  - 1xx OCREF: level = oc_ref_i[mms_i[1:0]]. If mms_i[1:0] >= 2*CH_PAIRS_NUM, the level is 0.
- mms_i is registered each cycle as mms_q. A change in mms_q, compared with the previous cycle, is a mode change.
- Level modes: trgo_o is the registered level, 1 cycle after the input. FSM stays in IDLE; busy_o=0.
- Event modes use FSM states IDLE and PULSE, plus a down-counter cnt.
  - IDLE, event: go to PULSE. cnt = max(pw_i,1) - 1. trgo_o=1 from the next cycle.
  - PULSE, cnt>0, no event: cnt decrements; trgo_o stays 1.
  - PULSE, event: retrigger. cnt reloads to max(pw_i,1) - 1; trgo_o stays 1 with no gap, so the pulse is extended.
  - PULSE, cnt==0, no event: go to IDLE; trgo_o=0 from the next cycle.
  - Result: one isolated event gives trgo_o high for exactly max(pw_i,1) cycles, starting 1 cycle after the strobe.
- pw_i is sampled only at load or reload. Changing pw_i during PULSE does not affect the current count.
- Mode change has priority over everything:
  - FSM goes to IDLE and cnt=0.
  - trgo_o=0 for exactly 1 cycle.
  - The new source takes effect on the following cycle.
  - An event on the same cycle as the mode change is dropped.
- Simultaneous ug_i and slv_rst_i in mode 000 count as one event.
- busy_o = (FSM==PULSE).
- MSM:
  - msm_i=1: trgi_sync_o = trgi_i delayed by 1 register, the same latency as trgo_o.
  - msm_i=0: trgi_sync_o = trgi_i, combinational pass-through.
  - The delay register is always clocked, so toggling msm_i does not need a flush.
- Reset asserted mid-pulse: all state clears immediately and asynchronously; trgo_o goes to 0.
- After reset release, the first event is accepted on the first rising edge.

Decomposition:
- Shared package gpt_trig_pkg:
  - mms_e enum: MMS_RESET, MMS_ENABLE, MMS_UPDATE, MMS_CMP_PULSE, MMS_OC1REF to MMS_OC4REF.
  - mm_state_e enum: MM_IDLE, MM_PULSE.
  - PULSE_W_MAX default constant.
- Sub-module trgo_pulse_stretcher holds the FSM, counter and retrigger logic.
  - Ports: clk_i, aresetn_i, evt_i, clr_i, pw_i, pulse_o, busy_o.
  - The top level does source muxing, mode-change detection, level registering and the MSM path.

Test Plan:
- Mode 010, pw_i=3, single uev_i at cycle 10 -> trgo_o high during cycles 11-13, low at cycle 14; busy_o matches trgo_o.
- Mode 000, pw_i=4, ug_i at cycle 5 and slv_rst_i at cycle 7 -> trgo_o high during cycles 6-11, continuous with no gap.
- Mode 011, pw_i=0, cc1_evt_i on two consecutive cycles 20 and 21 -> trgo_o high during cycles 21-22.
- Mode 1xx sweep with CH_PAIRS_NUM=1:
  - mms_i=101, oc_ref_i=2'b10 -> trgo_o=1 one cycle later.
  - mms_i=110 -> trgo_o=0 regardless of oc_ref_i.
- Mode change mid-pulse: mode 010, pw_i=8, uev_i at cycle 3, switch to 001 with cen_i=1 at cycle 6.
  - trgo_o=0 at cycle 7 and 1 from cycle 8.
  - busy_o=0 from cycle 7.
- MSM check:
  - msm_i=1, trgi_i pulse at cycle 4 -> trgi_sync_o at cycle 5.
  - msm_i=0 -> trgi_sync_o at cycle 4.
- Reset check: aresetn_i low mid-pulse -> trgo_o and busy_o go to 0 immediately.
